// File: rtl/l4_fc_seq_pkg.sv
// Shared types and constants for the layer-4 FC weight sequencer.
// Holds the FSM state enum, default geometry and a geometry check.
package l4_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int L4_ADDR_W     = 6;
  localparam int L4_ROW_STRIDE = 16;
  localparam int L4_NUM_ROWS   = 4;

  // A pass must stay inside the ROM, and row_idx
  // must be exactly wide enough to count the rows.
  function automatic bit l4_params_ok(
    input int addr_w,
    input int stride,
    input int rows,
    input int row_w
  );
    return (rows * stride <= (1 << addr_w)) &&
           (row_w == $clog2(rows));
  endfunction

  localparam bit L4_CFG_OK =
    l4_params_ok(L4_ADDR_W, L4_ROW_STRIDE,
                 L4_NUM_ROWS, $clog2(L4_NUM_ROWS));

endpackage

// File: rtl/l4_fc_seq_if.sv
// Weight-row handshake between the sequencer and ROM/MAC array.
// master: rom_addr, wt_valid, row_idx, row_last out; wt_ready in.
interface l4_fc_seq_if #(
  parameter int ADDR_W = 6,
  parameter int ROW_W  = 2
);

  logic [ADDR_W-1:0] rom_addr;
  logic              wt_valid;
  logic              wt_ready;
  logic [ROW_W-1:0]  row_idx;
  logic              row_last;

  modport master (
    output rom_addr,
    output wt_valid,
    output row_idx,
    output row_last,
    input  wt_ready
  );

  modport slave (
    input  rom_addr,
    input  wt_valid,
    input  row_idx,
    input  row_last,
    output wt_ready
  );

endinterface

// File: rtl/l4_fc_seq.sv
// Layer-4 FC weight ROM sequencer: steps row bases, handshakes rows.
// Ports: clk, rst_n, start, abort, wt (master), acc_clr, busy, done.
module l4_fc_seq
  import l4_pkg::*;
#(
  parameter int ADDR_W     = L4_ADDR_W,
  parameter int ROW_STRIDE = L4_ROW_STRIDE,
  parameter int NUM_ROWS   = L4_NUM_ROWS,
  parameter int ROW_W      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  l4_fc_seq_if.master  wt,
  output logic         acc_clr,
  output logic         busy,
  output logic         done
);

  if (!l4_params_ok(ADDR_W, ROW_STRIDE,
                    NUM_ROWS, ROW_W)) begin : g_bad_cfg
    $error("l4_fc_seq: illegal row geometry");
  end

  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(ROW_STRIDE);
  localparam logic [ROW_W-1:0] LAST_ROW =
    ROW_W'(NUM_ROWS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ROW_W-1:0]  r_row;
  logic              r_valid;
  logic              r_last;
  logic              r_clr;
  logic              r_busy;
  logic              r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      // Drops any in-flight row, even one
      // being accepted this very cycle.
      r_state <= IDLE;
      r_addr  <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_clr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= FETCH;
            r_addr  <= '0;
            r_row   <= '0;
            r_clr   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          // ROM dout settles during this cycle.
          r_clr   <= 1'b0;
          r_state <= ISSUE;
          r_valid <= 1'b1;
          r_last  <= (r_row == LAST_ROW);
        end
        ISSUE: begin
          if (wt.wt_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
              r_addr  <= r_addr + STEP;
              r_row   <= r_row + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_row   <= '0;
        end
      endcase
    end
  end

  assign wt.rom_addr = r_addr;
  assign wt.wt_valid = r_valid;
  assign wt.row_idx  = r_row;
  assign wt.row_last = r_last;
  assign acc_clr     = r_clr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_l4_fc_seq.sv
// Directed bench for l4_fc_seq with a behavioural weight ROM.
// Vector table plus hand sequences for stall, abort and reset.
module tb_l4_fc_seq;
  import l4_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic acc_clr;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  l4_fc_seq_if #(.ADDR_W(6), .ROW_W(2)) wt ();

  l4_fc_seq #(
    .ADDR_W(6), .ROW_STRIDE(16),
    .NUM_ROWS(4), .ROW_W(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .wt      (wt.master),
    .acc_clr (acc_clr),
    .busy    (busy),
    .done    (done)
  );

  logic [8:0] rom [64];
  logic [15:0][8:0] dout;

  function automatic logic [8:0] img(input int a);
    return 9'((a * 37 + 5) % 512);
  endfunction

  function automatic logic [15:0][8:0] img_row(input int a);
    logic [15:0][8:0] r;
    for (int i = 0; i < 16; i++) r[i] = img(a + i);
    return r;
  endfunction

  always_ff @(posedge clk)
    for (int i = 0; i < 16; i++)
      dout[i] <= rom[(int'(wt.rom_addr) + i) % 64];

  int hs_cnt;
  int done_cnt;
  always @(posedge clk) begin
    if (wt.wt_valid && wt.wt_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    wt.wt_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, wt.rom_addr, wt.wt_valid,
            wt.row_idx, wt.row_last,
            acc_clr, busy, done};
  endfunction

  typedef struct {
    logic       st;
    logic       ab;
    logic       rdy;
    logic [5:0] addr;
    logic       v;
    logic [1:0] idx;
    logic       last;
    logic       clr;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, ab, rdy,
                     input logic [5:0] addr,
                     input logic v,
                     input logic [1:0] idx,
                     input logic last, clr, bsy, dn);
    vec_t e;
    e.st = st; e.ab = ab; e.rdy = rdy;
    e.addr = addr; e.v = v; e.idx = idx;
    e.last = last; e.clr = clr;
    e.bsy = bsy; e.dn = dn;
    tbl.push_back(e);
  endtask

  // Runs one pass with wt_ready high from a start pulse;
  // returns the cycle (start = 0) in which done is seen.
  task automatic clean_pass(output int dcyc);
    dcyc = -1;
    hs_cnt = 0;
    done_cnt = 0;
    wt.wt_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      tick();
    end
    tick();
  endtask

  int dc;
  logic [15:0][8:0] held;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = img(i);
    hs_cnt = 0;
    done_cnt = 0;
    do_reset();

    // Idle after reset.
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("idle c%0d", c), outs(), 32'd0);
      tick();
    end

    // Full pass; start mid-pass and in DONE ignored.
    add(1,0,1,  0,0,0,0,1,1,0);
    add(0,0,1,  0,1,0,0,0,1,0);
    add(0,0,1, 16,0,1,0,0,1,0);
    add(0,0,1, 16,1,1,0,0,1,0);
    add(1,0,1, 32,0,2,0,0,1,0);
    add(0,0,1, 32,1,2,0,0,1,0);
    add(0,0,1, 48,0,3,0,0,1,0);
    add(0,0,1, 48,1,3,1,0,1,0);
    add(0,0,1, 48,0,3,0,0,1,1);
    add(1,0,1,  0,0,0,0,0,0,0);
    add(0,0,1,  0,0,0,0,0,0,0);
    // start together with abort: abort wins.
    add(1,1,1,  0,0,0,0,0,0,0);
    add(0,0,1,  0,0,0,0,0,0,0);
    // Abort in ISSUE at row 2 with ready high.
    add(1,0,1,  0,0,0,0,1,1,0);
    add(0,0,1,  0,1,0,0,0,1,0);
    add(0,0,1, 16,0,1,0,0,1,0);
    add(0,0,1, 16,1,1,0,0,1,0);
    add(0,0,1, 32,0,2,0,0,1,0);
    add(0,0,1, 32,1,2,0,0,1,0);
    add(0,1,1,  0,0,0,0,0,0,0);
    add(0,0,1,  0,0,0,0,0,0,0);
    add(0,0,1,  0,0,0,0,0,0,0);

    foreach (tbl[i]) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      wt.wt_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {18'd0, tbl[i].addr, tbl[i].v,
           tbl[i].idx, tbl[i].last,
           tbl[i].clr, tbl[i].bsy, tbl[i].dn});
    end
    start = 1'b0;
    abort = 1'b0;

    // Clean pass after abort.
    clean_pass(dc);
    chk("post-abort done cyc", dc, 9);
    chk("post-abort hs", hs_cnt, 4);
    chk("post-abort done cnt", done_cnt, 1);

    // Backpressure on row 1 for 5 cycles.
    hs_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wt.wt_ready = 1'b0;
    held = img_row(16);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("stall%0d valid", k),
          wt.wt_valid, 1);
      chk($sformatf("stall%0d addr", k),
          wt.rom_addr, 16);
      chk($sformatf("stall%0d idx", k),
          wt.row_idx, 1);
      n_chk++;
      if (dout !== held) begin
        n_fail++;
        $display("FAIL stall%0d dout: got %h expected %h",
                 k, dout, held);
      end
    end
    wt.wt_ready = 1'b1;
    dc = -1;
    for (int c = 9; c < 40; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      tick();
    end
    chk("stall done cyc", dc, 14);
    tick();
    chk("stall hs", hs_cnt, 4);
    chk("stall done cnt", done_cnt, 1);

    // Second start while busy at row 2.
    hs_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      start = (wt.row_idx == 2'd2 && !wt.wt_valid);
      tick();
    end
    start = 1'b0;
    chk("busy-start hs", hs_cnt, 4);
    chk("busy-start done cnt", done_cnt, 1);
    chk("busy-start idle", outs(), 32'd0);

    // Async reset between edges during ISSUE.
    hs_cnt = 0;
    done_cnt = 0;
    wt.wt_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre-rst valid", wt.wt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst outs", outs(), 32'd0);
    tick();
    chk("rst held outs", outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst done cnt", done_cnt, 0);
    clean_pass(dc);
    chk("post-rst done cyc", dc, 9);
    chk("post-rst hs", hs_cnt, 4);
    chk("post-rst done cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
